// File: rtl/inst_loader.sv
// Boot-time instruction memory loader: framed big-endian byte stream to word writes.
// Optional trailing XOR checksum byte compiled in with LOADER_CHECKSUM_EN.
module inst_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Byte_Valid,
    input  logic [7:0]            Byte_Data,
    output logic                  Byte_Ready,
    output logic                  Mem_Write_En,
    output logic [ADDR_WIDTH-1:0] Mem_Write_Addr,
    output logic [31:0]           Mem_Write_Data,
    output logic                  Cpu_Hold,
    output logic                  Done,
    output logic                  Error
);

    localparam logic [2:0] S_CNT_HI = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CSUM   = 3'd3;
`endif
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

    logic [2:0]            state;
    logic [7:0]            cnt_hi;
    logic [ADDR_WIDTH:0]   n_words;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [1:0]            byte_cnt;
    logic [23:0]           word;
    logic                  done_r;
    logic                  error_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    logic        accept;
    logic [15:0] count_next;
    logic        last_word;

    assign Byte_Ready = (state != S_DONE) && (state != S_ERROR);
    assign accept     = Byte_Valid && Byte_Ready;
    assign count_next = {cnt_hi, Byte_Data};
    assign last_word  = (word_cnt + 1'b1) == n_words;
    assign Done       = done_r;
    assign Error      = error_r;
    assign Cpu_Hold   = !done_r;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state          <= S_CNT_HI;
            cnt_hi         <= '0;
            n_words        <= '0;
            word_cnt       <= '0;
            byte_cnt       <= '0;
            word           <= '0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            Mem_Write_En   <= 1'b0;
            Mem_Write_Addr <= '0;
            Mem_Write_Data <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum           <= '0;
`endif
        end else begin
            Mem_Write_En <= 1'b0;
`ifndef LOADER_CHECKSUM_EN
            // Done trails the final write pulse by one cycle
            if (state == S_DONE)
                done_r <= 1'b1;
`endif
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                csum <= csum ^ Byte_Data;
`endif
                case (state)
                    S_CNT_HI: begin
                        cnt_hi <= Byte_Data;
                        state  <= S_CNT_LO;
                    end
                    S_CNT_LO: begin
                        n_words <= count_next[ADDR_WIDTH:0];
                        if ({1'b0, count_next} > MAX_WORDS) begin
                            state   <= S_ERROR;
                            error_r <= 1'b1;
                        end else if (count_next == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_DONE;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word     <= {word[15:0], Byte_Data};
                        if (byte_cnt == 2'd3) begin
                            Mem_Write_En   <= 1'b1;
                            Mem_Write_Addr <= word_cnt[ADDR_WIDTH-1:0];
                            Mem_Write_Data <= {word, Byte_Data};
                            word_cnt       <= word_cnt + 1'b1;
                            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state <= S_DONE;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (Byte_Data == csum) begin
                            state  <= S_DONE;
                            done_r <= 1'b1;
                        end else begin
                            state   <= S_ERROR;
                            error_r <= 1'b1;
                        end
                    end
`endif
                    default: state <= state;
                endcase
            end
        end
    end

endmodule
